// File: rtl/imm_gen_stage.sv
// Registered RISC-V immediate-generation stage: decodes the incoming instruction
// and holds the result in a 2-entry in-order skid buffer between fetch and execute.

module imm_gen_dec #(
  parameter int XLEN           = 64,
  parameter bit BJ_BYTE_OFFSET = 1'b1
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      typ,
  output logic            illegal
);
  localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3,
                         T_U = 3'd4, T_J = 3'd5, T_Z = 3'd6, T_ILL = 3'd7;

  logic        s;
  logic [31:0] i32, s32, b32, j32, u32;

  // Every field is first sign-extended to 32 bits, then widened to XLEN.
  function automatic logic [XLEN-1:0] sx(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  always_comb begin
    s   = instr[31];
    i32 = {{20{s}}, instr[31:20]};
    s32 = {{20{s}}, instr[31:25], instr[11:7]};
    b32 = BJ_BYTE_OFFSET ? {{19{s}}, s, instr[7], instr[30:25], instr[11:8], 1'b0}
                         : {{20{s}}, s, instr[7], instr[30:25], instr[11:8]};
    j32 = BJ_BYTE_OFFSET ? {{11{s}}, s, instr[19:12], instr[20], instr[30:21], 1'b0}
                         : {{12{s}}, s, instr[19:12], instr[20], instr[30:21]};
    u32 = {instr[31:12], 12'b0};
  end

  always_comb begin
    imm = '0;
    typ = T_ILL;
    unique case (instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111: begin imm = sx(i32); typ = T_I; end
      7'b0100011: begin imm = sx(s32); typ = T_S; end
      7'b1100011: begin imm = sx(b32); typ = T_B; end
      7'b1101111: begin imm = sx(j32); typ = T_J; end
      7'b0110111, 7'b0010111: begin imm = sx(u32); typ = T_U; end
      7'b0110011: typ = T_R;
      7'b1110011: begin
        if (instr[14:12] == 3'b000) begin
          imm = sx(i32);
          typ = T_I;
        end else begin
          imm = {{(XLEN-5){1'b0}}, instr[19:15]};
          typ = T_Z;
        end
      end
      // RV64-only word ops
      7'b0011011: if (XLEN == 64) begin imm = sx(i32); typ = T_I; end
      7'b0111011: if (XLEN == 64) typ = T_R;
      default: typ = T_ILL;
    endcase
    illegal = (typ == T_ILL);
  end
endmodule

module imm_gen_stage #(
  parameter int XLEN           = 64,
  parameter bit BJ_BYTE_OFFSET = 1'b1,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_type,
  output logic             out_illegal,
  output logic [31:0]      out_instr,
  output logic [XLEN-1:0]  out_pc,
  output logic [CNT_W-1:0] illegal_cnt
);
  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      typ;
    logic            illegal;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t          mem [2];
  entry_t          dec, head;
  logic            rd_ptr, wr_ptr;
  logic [1:0]      count;
  logic            push, pop;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_typ;
  logic            dec_ill;

  imm_gen_dec #(.XLEN(XLEN), .BJ_BYTE_OFFSET(BJ_BYTE_OFFSET)) u_dec (
    .instr   (in_instr),
    .imm     (dec_imm),
    .typ     (dec_typ),
    .illegal (dec_ill)
  );

  always_comb begin
    dec.imm     = dec_imm;
    dec.typ     = dec_typ;
    dec.illegal = dec_ill;
    dec.instr   = in_instr;
    dec.pc      = in_pc;
  end

  // in_ready depends only on registered count, never on out_ready.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign head      = mem[rd_ptr];

  assign out_imm     = head.imm;
  assign out_type    = head.typ;
  assign out_illegal = head.illegal;
  assign out_instr   = head.instr;
  assign out_pc      = head.pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0]      <= '0;
      mem[1]      <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= 2'd0;
      illegal_cnt <= '0;
    end else begin
      if (flush) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= dec;
          wr_ptr      <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        count <= count + {1'b0, push} - {1'b0, pop};
      end
      if (push && dec.illegal && (illegal_cnt != {CNT_W{1'b1}}))
        illegal_cnt <= illegal_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: an RV64 byte-offset instance and an RV32
// halfword-offset instance with a narrow counter for saturation.
module tb_imm_gen_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  logic        a_flush = 0, a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0, a_out_illegal;
  logic [31:0] a_in_instr = 0, a_out_instr;
  logic [63:0] a_in_pc = 0, a_out_imm, a_out_pc;
  logic [2:0]  a_out_type;
  logic [15:0] a_cnt;

  logic        b_flush = 0, b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 1, b_out_illegal;
  logic [31:0] b_in_instr = 0, b_out_instr, b_in_pc = 0, b_out_imm, b_out_pc;
  logic [2:0]  b_out_type;
  logic [2:0]  b_cnt;

  imm_gen_stage #(.XLEN(64), .BJ_BYTE_OFFSET(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_instr(a_in_instr), .in_pc(a_in_pc), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_imm(a_out_imm), .out_type(a_out_type), .out_illegal(a_out_illegal),
    .out_instr(a_out_instr), .out_pc(a_out_pc), .illegal_cnt(a_cnt));

  imm_gen_stage #(.XLEN(32), .BJ_BYTE_OFFSET(1'b0), .CNT_W(3)) dut_b (
    .clk(clk), .reset(reset), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_instr(b_in_instr), .in_pc(b_in_pc), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_imm(b_out_imm), .out_type(b_out_type), .out_illegal(b_out_illegal),
    .out_instr(b_out_instr), .out_pc(b_out_pc), .illegal_cnt(b_cnt));

  task automatic push_a(input logic [31:0] ins, input logic [63:0] pc);
    a_in_valid = 1; a_in_instr = ins; a_in_pc = pc;
    @(posedge clk); #1;
    a_in_valid = 0;
  endtask

  task automatic push_b(input logic [31:0] ins);
    b_in_valid = 1; b_in_instr = ins;
    @(posedge clk); #1;
    b_in_valid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    nvec++; if (a_out_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid: got %b want 0", a_out_valid); end
    nvec++; if (a_out_imm !== 64'h0) begin nerr++; $display("FAIL rst_imm: got %h want 0", a_out_imm); end
    nvec++; if (a_cnt !== 16'h0) begin nerr++; $display("FAIL rst_cnt: got %h want 0", a_cnt); end
    @(negedge clk); reset = 0;
    @(posedge clk); #1;
    nvec++; if (a_in_ready !== 1'b1) begin nerr++; $display("FAIL rst_in_ready: got %b want 1", a_in_ready); end
  endtask

  task automatic test_decode;
    logic [31:0] ins [12];
    logic [63:0] eimm [12];
    logic [2:0]  etyp [12];
    ins  = '{32'hFFF00093, 32'hFE000EE3, 32'hFFDFF06F, 32'hFE112C23, 32'h800000B7, 32'h002081B3,
             32'h300FD0F3, 32'h00000073, 32'h0050809B, 32'h00B5053B, 32'h0FF0000F, 32'h00001017};
    eimm = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC,
             64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_8000_0000, 64'h0, 64'h1F, 64'h0, 64'h5,
             64'h0, 64'hFF, 64'h1000};
    etyp = '{3'd1, 3'd3, 3'd5, 3'd2, 3'd4, 3'd0, 3'd6, 3'd1, 3'd1, 3'd0, 3'd1, 3'd4};
    a_out_ready = 1;
    for (int i = 0; i < 12; i++) begin
      push_a(ins[i], 64'h8000_0000 + 64'(i * 4));
      nvec++; if (a_out_valid !== 1'b1) begin nerr++; $display("FAIL dec_valid[%0d]: got %b want 1", i, a_out_valid); end
      nvec++; if (a_out_imm !== eimm[i]) begin nerr++; $display("FAIL dec_imm[%0d]: got %h want %h", i, a_out_imm, eimm[i]); end
      nvec++; if (a_out_type !== etyp[i]) begin nerr++; $display("FAIL dec_type[%0d]: got %0d want %0d", i, a_out_type, etyp[i]); end
      nvec++; if (a_out_illegal !== 1'b0) begin nerr++; $display("FAIL dec_ill[%0d]: got %b want 0", i, a_out_illegal); end
      nvec++; if (a_out_pc !== 64'h8000_0000 + 64'(i * 4)) begin nerr++; $display("FAIL dec_pc[%0d]: got %h", i, a_out_pc); end
    end
    idle(1);
    nvec++; if (a_out_valid !== 1'b0) begin nerr++; $display("FAIL dec_drain: got %b want 0", a_out_valid); end
  endtask

  task automatic test_back_to_back;
    a_out_ready = 0;
    a_in_valid = 1; a_in_instr = 32'h00100093;
    @(posedge clk); #1;
    nvec++; if (a_in_ready !== 1'b1) begin nerr++; $display("FAIL bp_ready1: got %b want 1", a_in_ready); end
    a_in_instr = 32'h00200093;
    @(posedge clk); #1;
    nvec++; if (a_in_ready !== 1'b0) begin nerr++; $display("FAIL bp_ready2: got %b want 0", a_in_ready); end
    a_in_instr = 32'h00300093;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      nvec++; if (a_out_instr !== 32'h00100093 || a_out_imm !== 64'd1) begin nerr++; $display("FAIL bp_hold[%0d]: got %h/%h want 00100093/1", k, a_out_instr, a_out_imm); end
      nvec++; if (a_in_ready !== 1'b0) begin nerr++; $display("FAIL bp_full[%0d]: got %b want 0", k, a_in_ready); end
    end
    a_out_ready = 1;
    @(posedge clk); #1;
    nvec++; if (a_out_instr !== 32'h00200093 || a_out_imm !== 64'd2) begin nerr++; $display("FAIL bp_second: got %h/%h", a_out_instr, a_out_imm); end
    nvec++; if (a_in_ready !== 1'b1) begin nerr++; $display("FAIL bp_ready_rise: got %b want 1", a_in_ready); end
    @(posedge clk); #1;
    a_in_valid = 0;
    nvec++; if (a_out_instr !== 32'h00300093 || a_out_imm !== 64'd3 || a_out_valid !== 1'b1) begin nerr++; $display("FAIL bp_third: got %h/%h v=%b", a_out_instr, a_out_imm, a_out_valid); end
    idle(1);
    nvec++; if (a_out_valid !== 1'b0) begin nerr++; $display("FAIL bp_empty: got %b want 0", a_out_valid); end
  endtask

  task automatic test_illegal;
    a_out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      push_a(32'h0000007F, 64'h0);
      nvec++; if (a_out_type !== 3'd7 || a_out_illegal !== 1'b1 || a_out_imm !== 64'h0) begin nerr++; $display("FAIL ill_a[%0d]: got t=%0d i=%b imm=%h", i, a_out_type, a_out_illegal, a_out_imm); end
    end
    nvec++; if (a_cnt !== 16'd4) begin nerr++; $display("FAIL ill_cnt_a: got %0d want 4", a_cnt); end
    idle(1);
    for (int i = 0; i < 4; i++) begin
      push_b(i == 3 ? 32'h0000001B : 32'h0000007F);
      nvec++; if (b_out_type !== 3'd7 || b_out_illegal !== 1'b1) begin nerr++; $display("FAIL ill_b[%0d]: got t=%0d i=%b", i, b_out_type, b_out_illegal); end
    end
    nvec++; if (b_cnt !== 3'd4) begin nerr++; $display("FAIL ill_cnt_b: got %0d want 4", b_cnt); end
    push_b(32'h800000B7);
    nvec++; if (b_out_imm !== 32'h8000_0000 || b_out_type !== 3'd4) begin nerr++; $display("FAIL b_lui: got %h t=%0d want 80000000 t=4", b_out_imm, b_out_type); end
    push_b(32'hFE000EE3);
    nvec++; if (b_out_imm !== 32'hFFFF_FFFE || b_out_type !== 3'd3) begin nerr++; $display("FAIL b_beq: got %h t=%0d want fffffffe t=3", b_out_imm, b_out_type); end
    push_b(32'hFFDFF06F);
    nvec++; if (b_out_imm !== 32'hFFFF_FFFE || b_out_type !== 3'd5) begin nerr++; $display("FAIL b_jal: got %h t=%0d want fffffffe t=5", b_out_imm, b_out_type); end
    for (int i = 0; i < 4; i++) push_b(32'h0000003B);
    nvec++; if (b_cnt !== 3'd7) begin nerr++; $display("FAIL ill_sat_b: got %0d want 7", b_cnt); end
    idle(1);
  endtask

  task automatic test_flush;
    a_out_ready = 0;
    push_a(32'h00100093, 64'h10);
    push_a(32'h0000007F, 64'h14);
    a_in_valid = 1; a_in_instr = 32'h00500093; a_flush = 1;
    @(posedge clk); #1;
    a_in_valid = 0; a_flush = 0;
    nvec++; if (a_out_valid !== 1'b0) begin nerr++; $display("FAIL flush_full: got %b want 0", a_out_valid); end
    nvec++; if (a_cnt !== 16'd5) begin nerr++; $display("FAIL flush_cnt: got %0d want 5", a_cnt); end
    push_a(32'h00600093, 64'h20);
    a_in_valid = 1; a_in_instr = 32'h00700093; a_flush = 1;
    @(posedge clk); #1;
    a_in_valid = 0; a_flush = 0;
    nvec++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin nerr++; $display("FAIL flush_one: got v=%b r=%b want 0/1", a_out_valid, a_in_ready); end
    a_out_ready = 1;
    push_a(32'h00800093, 64'h30);
    nvec++; if (a_out_imm !== 64'd8 || a_out_pc !== 64'h30) begin nerr++; $display("FAIL flush_after: got %h/%h want 8/30", a_out_imm, a_out_pc); end
    idle(1);
  endtask

  task automatic test_async_reset;
    a_out_ready = 0;
    push_a(32'hFFF00093, 64'h40);
    push_a(32'h0000007F, 64'h44);
    #3 reset = 1;
    #1;
    nvec++; if (a_out_valid !== 1'b0 || a_out_imm !== 64'h0) begin nerr++; $display("FAIL arst_out: got v=%b imm=%h want 0/0", a_out_valid, a_out_imm); end
    nvec++; if (a_cnt !== 16'h0 || a_out_pc !== 64'h0 || a_out_type !== 3'd0) begin nerr++; $display("FAIL arst_regs: got cnt=%0d pc=%h t=%0d", a_cnt, a_out_pc, a_out_type); end
    @(negedge clk); reset = 0;
    @(posedge clk); #1;
    nvec++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin nerr++; $display("FAIL arst_release: got r=%b v=%b want 1/0", a_in_ready, a_out_valid); end
    a_out_ready = 1;
    push_a(32'h00100093, 64'h50);
    nvec++; if (a_out_valid !== 1'b1 || a_out_imm !== 64'd1) begin nerr++; $display("FAIL arst_push: got v=%b imm=%h want 1/1", a_out_valid, a_out_imm); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
